// File: rtl/gate_check_pkg.sv
// Shared types for the 2-input gate checker: expected-gate opcodes, FSM states,
// vector count, and a helper that flags reserved opcodes.
// No ports; imported by gate_checker_if, gate_ref and gate_checker.
package gate_check_pkg;

  localparam int NUM_VECTORS = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Codes 6 and 7 have no gate behind them.
  function automatic logic op_reserved(input logic [2:0] op);
    return (op > 3'd5);
  endfunction

endpackage

// File: rtl/gate_checker_if.sv
// Run-control and gate-under-test bundle for gate_checker.
// master: requester/harness side (start, op_sel, dut_c out; stimulus and results in).
// slave : checker side (drives dut_a/dut_b, busy, done and the result fields).
interface gate_checker_if;
  import gate_check_pkg::*;

  logic       start;
  logic [2:0] op_sel;
  logic       dut_a;
  logic       dut_b;
  logic       dut_c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic       bad_op;

  modport master (
    output start, op_sel, dut_c,
    input  dut_a, dut_b, busy, done, pass, err_count, fail_vec, bad_op
  );

  modport slave (
    input  start, op_sel, dut_c,
    output dut_a, dut_b, busy, done, pass, err_count, fail_vec, bad_op
  );

endinterface

// File: rtl/gate_ref.sv
// Golden model of the 2-input gate selected by op; purely combinational.
// Ports: op (3-bit opcode), a, b (gate inputs), expected (gate output).
// Reserved opcodes yield 0; the checker never samples against them.
module gate_ref
  import gate_check_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_NAND: expected = ~(a & b);
      OP_NOR:  expected = ~(a | b);
      OP_XOR:  expected = a ^ b;
      OP_XNOR: expected = ~(a ^ b);
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_checker.sv
// Exhaustive 2-input gate checker: walks {a,b}=00..11, compares dut_c to gate_ref.
// Latency: done 4*(SETTLE_CYCLES+1) cycles after start acceptance (1 for reserved op).
// Ports: clk, rst_n (async active-low), io (slave modport); start ignored while busy.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  gate_checker_if.slave  io
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      vec_q, vec_d;
  logic [2:0]      op_q;
  logic [2:0]      err_q;
  logic [3:0]      fail_q;
  logic            pass_q;
  logic            bad_q, bad_d;
  logic            a_q, b_q;
  logic            expected;
  logic            mismatch;
  logic            accept;
  logic            drive_d;

  gate_ref u_ref (
    .op       (op_q),
    .a        (vec_q[1]),
    .b        (vec_q[0]),
    .expected (expected)
  );

  assign accept   = (state_q == ST_IDLE) && io.start;
  assign mismatch = (state_q == ST_SAMPLE) && (io.dut_c != expected);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          vec_d   = 2'd0;
          bad_d   = op_reserved(io.op_sel);
        end
      end
      ST_DRIVE: begin
        // A reserved op spends one DRIVE cycle with outputs parked at 0 so
        // that DONE lands on the same edge for every rejected run.
        if (bad_q) begin
          state_d = ST_DONE;
        end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SAMPLE: begin
        cnt_d = '0;
        if (vec_q == 2'(NUM_VECTORS - 1)) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    drive_d = ((state_d == ST_DRIVE) || (state_d == ST_SAMPLE)) && !bad_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      op_q    <= 3'd0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
      bad_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      bad_q   <= bad_d;
      // Stimulus is registered from next-state so it changes on the same
      // edge the vector index does and stays flat through DRIVE+SAMPLE.
      a_q     <= drive_d & vec_d[1];
      b_q     <= drive_d & vec_d[0];
      if (accept) begin
        op_q   <= io.op_sel;
        err_q  <= 3'd0;
        fail_q <= 4'd0;
        pass_q <= 1'b0;
      end
      if (mismatch) begin
        fail_q[vec_q] <= 1'b1;
        if (err_q < 3'd4) err_q <= err_q + 3'd1;
      end
      // Verdict is taken on entry to DONE, folding in the final comparison.
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
        pass_q <= !bad_q && (err_q == 3'd0) && !mismatch;
      end
    end
  end

  assign io.dut_a     = a_q;
  assign io.dut_b     = b_q;
  assign io.busy      = (state_q != ST_IDLE);
  assign io.done      = (state_q == ST_DONE);
  assign io.pass      = pass_q;
  assign io.err_count = err_q;
  assign io.fail_vec  = fail_q;
  assign io.bad_op    = bad_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker wrapping a 2-input AND gate as the gate under test.
// Expected run results are queued at start and popped when done pulses.
// SETTLE_CYCLES=2: stimulus edges counted from the accepting edge (edge 0).
module tb_gate_checker;
  import gate_check_pkg::*;

  typedef struct packed {
    logic [3:0] fail_vec;
    logic [2:0] err_count;
    logic       pass;
    logic       bad_op;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_checker_if ifc ();
  assign ifc.dut_c = ifc.dut_a & ifc.dut_b;

  gate_checker #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  res_t sb[$];

  function automatic logic golden(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return !(a & b);
      3'd3: return !(a | b);
      3'd4: return a ^ b;
      3'd5: return a == b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic res_t model(input logic [2:0] op);
    res_t r;
    r = '0;
    if (op > 3'd5) begin
      r.bad_op = 1'b1;
      return r;
    end
    for (int v = 0; v < 4; v++) begin
      logic a, b;
      a = v[1];
      b = v[0];
      if ((a & b) != golden(op, a, b)) begin
        r.fail_vec[v] = 1'b1;
        r.err_count   = r.err_count + 3'd1;
      end
    end
    r.pass = (r.err_count == 3'd0);
    return r;
  endfunction

  task automatic run_op(input logic [2:0] op, input bit extra, input string name);
    res_t       exp_r, got, obs;
    int         exp_done, n_done;
    logic [1:0] exp_ab;
    exp_r = model(op);
    sb.push_back(exp_r);
    exp_done = exp_r.bad_op ? 1 : 12;
    n_done   = 0;
    @(negedge clk);
    ifc.op_sel = op;
    ifc.start  = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    n_total++;
    if ({ifc.busy, ifc.done, ifc.pass, ifc.err_count, ifc.fail_vec, ifc.bad_op, ifc.dut_a, ifc.dut_b}
        !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, exp_r.bad_op, 2'b00})
      $display("FAIL %s accept: busy=%b done=%b pass=%b err=%0d fv=%b bad=%b ab=%b%b, need busy=1 cleared bad=%b ab=00",
               name, ifc.busy, ifc.done, ifc.pass, ifc.err_count, ifc.fail_vec, ifc.bad_op,
               ifc.dut_a, ifc.dut_b, exp_r.bad_op);
    else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      if (extra && (k == 3 || k == 8)) ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      exp_ab = (exp_r.bad_op || k >= 12) ? 2'b00 : 2'(k / 3);
      n_total++;
      if ({ifc.dut_a, ifc.dut_b} !== exp_ab)
        $display("FAIL %s ab edge %0d: got %b%b need %b", name, k, ifc.dut_a, ifc.dut_b, exp_ab);
      else n_pass++;
      n_total++;
      if (ifc.done !== (k == exp_done))
        $display("FAIL %s done edge %0d: got %b need %b", name, k, ifc.done, (k == exp_done));
      else n_pass++;
      n_total++;
      if (ifc.busy !== (k <= exp_done))
        $display("FAIL %s busy edge %0d: got %b need %b", name, k, ifc.busy, (k <= exp_done));
      else n_pass++;
      if (ifc.done === 1'b1) begin
        n_done++;
        obs = {ifc.fail_vec, ifc.err_count, ifc.pass, ifc.bad_op};
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL %s scoreboard: done with no expected result queued", name);
        end else begin
          got = sb.pop_front();
          if (obs !== got)
            $display("FAIL %s result: got fv=%b err=%0d pass=%b bad=%b need fv=%b err=%0d pass=%b bad=%b",
                     name, obs.fail_vec, obs.err_count, obs.pass, obs.bad_op,
                     got.fail_vec, got.err_count, got.pass, got.bad_op);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (n_done !== 1)
      $display("FAIL %s done_pulses: got %0d need 1", name, n_done);
    else n_pass++;
    obs = {ifc.fail_vec, ifc.err_count, ifc.pass, ifc.bad_op};
    n_total++;
    if (obs !== exp_r)
      $display("FAIL %s hold: got %b need %b", name, obs, exp_r);
    else n_pass++;
  endtask

  task automatic test_reset();
    ifc.start  = 1'b0;
    ifc.op_sel = 3'd0;
    rst_n      = 1'b0;
    #12;
    n_total++;
    if ({ifc.busy, ifc.done, ifc.pass, ifc.err_count, ifc.fail_vec, ifc.bad_op, ifc.dut_a, ifc.dut_b} !== 12'd0)
      $display("FAIL reset_state: got %b need 0", {ifc.busy, ifc.done, ifc.pass, ifc.err_count,
               ifc.fail_vec, ifc.bad_op, ifc.dut_a, ifc.dut_b});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_and();  run_op(3'd0, 1'b0, "and");  endtask
  task automatic test_or();   run_op(3'd1, 1'b0, "or");   endtask
  task automatic test_nand(); run_op(3'd2, 1'b0, "nand"); endtask
  task automatic test_xor();  run_op(3'd4, 1'b0, "xor");  endtask
  task automatic test_extra_starts(); run_op(3'd1, 1'b1, "extra_starts"); endtask
  task automatic test_bad_op(); run_op(3'd6, 1'b0, "bad_op"); endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    ifc.op_sel = 3'd0;
    ifc.start  = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({ifc.busy, ifc.done, ifc.pass, ifc.err_count, ifc.fail_vec, ifc.bad_op, ifc.dut_a, ifc.dut_b} !== 12'd0)
      $display("FAIL mid_reset: got %b need 0", {ifc.busy, ifc.done, ifc.pass, ifc.err_count,
               ifc.fail_vec, ifc.bad_op, ifc.dut_a, ifc.dut_b});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 1'b0, "and_after_reset");
  endtask

  initial begin
    test_reset();
    test_and();
    test_or();
    test_nand();
    test_xor();
    test_extra_starts();
    test_reset_mid_run();
    test_bad_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, number of cycles (min 1) each input vector is held before dut_c is sampled.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  single-cycle run request, sampled in IDLE only.
REQ-005 op_sel  input  3  expected gate: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved.
REQ-006 dut_a  output  1  stimulus input a to the 2-input gate under test.
REQ-007 dut_b  output  1  stimulus input b to the 2-input gate under test.
REQ-008 dut_c  input  1  gate-under-test output c.
REQ-009 busy  output  1  high from the cycle after start acceptance until DONE is left.
REQ-010 done  output  1  one-cycle pulse marking end of run.
REQ-011 pass  output  1  1 when the last run completed with zero mismatches.
REQ-012 err_count  output  3  mismatch count of last run (0-4).
REQ-013 fail_vec  output  4  bit i set when vector i = {a,b} mismatched.
REQ-014 bad_op  output  1  last start used a reserved op_sel.

Function
REQ-015 FSM states shall be IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE + start=1 at edge 0: op_sel captured, err_count/fail_vec/pass/bad_op cleared, vector index=0, next state DRIVE.
REQ-017 Vector index v (0..3) shall drive dut_a=v[1], dut_b=v[0], registered, stable for the whole DRIVE+SAMPLE span of v.
REQ-018 DRIVE shall last exactly SETTLE_CYCLES cycles, then SAMPLE exactly one cycle.
REQ-019 At the edge leaving SAMPLE, dut_c shall be compared with the golden value for captured op on {v[1],v[0]}; mismatch sets fail_vec[v] and increments err_count.
REQ-020 After SAMPLE of v<3: v increments, state DRIVE; after v=3: state DONE.
REQ-021 DONE lasts one cycle with done=1, pass=(err_count==0), then IDLE; results hold until the next accepted start.
REQ-022 done shall rise at edge 4*(SETTLE_CYCLES+1) after the accepting edge (edge 12 for default).
REQ-023 start while not in IDLE shall be ignored; start held high re-triggers only after IDLE is re-entered.
REQ-024 Reserved op_sel at start: bad_op=1, pass=0, err_count=0, no vectors driven (dut_a=dut_b=0), state DONE at edge 1, done pulse in that cycle.
REQ-025 In IDLE and DONE, dut_a=dut_b=0.
REQ-026 err_count shall not wrap (maximum 4 fits 3 bits).

Reset
REQ-027 rst_n low shall immediately force state IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, bad_op=0, independent of clk.
REQ-028 Reset asserted mid-run shall abandon the run with no partial results retained; first start after release behaves per REQ-016.

Structure
REQ-029 Package gate_check_pkg shall hold the op_e enum (codes of REQ-005), state_e enum, and NUM_VECTORS=4.
REQ-030 Golden function shall be a combinational sub-module gate_ref (inputs op, a, b; output expected) instantiated once.

Verification (bench wraps a 2-input AND gate as the DUT, SETTLE_CYCLES=2)
REQ-031 op_sel=0, start pulse -> {dut_a,dut_b}=00,01,10,11 each held 3 cycles; done at edge 12; pass=1, err_count=0, fail_vec=0000.
REQ-032 op_sel=1 (OR) -> fail_vec=0110, err_count=2, pass=0, done at edge 12.
REQ-033 op_sel=2 (NAND) -> fail_vec=1111, err_count=4, pass=0.
REQ-034 Extra start pulses at edges 3 and 8 -> ignored, done still at edge 12 only; new start afterwards clears previous results.
REQ-035 rst_n low at edge 5 of a run -> all outputs 0 immediately, busy=0; after release, AND run yields pass=1 at edge 12 from its start.
REQ-036 op_sel=6 -> bad_op=1, done at edge 1, pass=0, dut_a=dut_b=0 throughout.
